// File: rtl/request_unit.sv
// rtl/request_unit.sv - memory request sequencer: I-fetch/data request issue, PC advance, halt and error latching
// Optional performance counters enabled by defining REQ_PERF_CNT_EN.
module request_unit #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cu_dREN,
  input  logic             cu_dWEN,
  input  logic             cu_halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halt,
  output logic             req_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        dren_q, dren_d;
  logic        dwen_q, dwen_d;
  logic        halt_q, halt_d;
  logic        err_q, err_d;
  logic [15:0] tmo_q, tmo_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      dren_q  <= dren_d;
      dwen_q  <= dwen_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dren_d  = dren_q;
    dwen_d  = dwen_q;
    halt_d  = halt_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    pc_en   = 1'b0;
    imemREN = (state_q == FETCH);
    case (state_q)
      FETCH: begin
        if (ihit) begin
          if (cu_halt) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else if (cu_dREN || cu_dWEN) begin
            // A store wins when the decoder asserts both; the conflict is still flagged.
            state_d = DATA;
            dren_d  = cu_dREN & ~cu_dWEN;
            dwen_d  = cu_dWEN;
            tmo_d   = '0;
            if (cu_dREN && cu_dWEN) err_d = 1'b1;
          end else begin
            pc_en = 1'b1;
          end
        end
      end
      DATA: begin
        if (dhit) begin
          pc_en   = 1'b1;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
          tmo_d   = '0;
          state_d = FETCH;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
          halt_d  = 1'b1;
          tmo_d   = '0;
          state_d = HALTED;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign dmemREN = dren_q;
  assign dmemWEN = dwen_q;
  assign halt    = halt_q;
  assign req_err = err_q;

`ifdef REQ_PERF_CNT_EN
  logic [CNT_W-1:0] icnt_q, scnt_q;

  // Counters saturate and freeze once halted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icnt_q <= '0;
      scnt_q <= '0;
    end else if (state_q != HALTED) begin
      if (pc_en && (icnt_q != '1)) icnt_q <= icnt_q + 1'b1;
      if (!pc_en && (scnt_q != '1)) scnt_q <= scnt_q + 1'b1;
    end
  end

  assign instr_cnt = icnt_q;
  assign stall_cnt = scnt_q;
`else
  assign instr_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule
